// File: rtl/ir_tx_encoder_if.sv
// Byte-enqueue bus between the APB IR peripheral and the IR transmit encoder.
// The peripheral drives MSG/ENQUEUE; the encoder reports BUF_FULL back.
interface ir_tx_encoder_if;
    logic [7:0] MSG;
    logic       ENQUEUE;
    logic       BUF_FULL;

    modport master (output MSG, output ENQUEUE, input BUF_FULL);
    modport slave  (input MSG, input ENQUEUE, output BUF_FULL);
endinterface

// File: rtl/ir_tx_encoder.sv
// IR transmit encoder: small byte FIFO feeding a pulse-distance frame generator
// with carrier modulation, envelope output and status strobes.
module ir_tx_encoder #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned UNIT_CYCLES   = 56000,
    parameter int unsigned CARRIER_HALF  = 1316,
    parameter int unsigned START_MARK_U  = 16,
    parameter int unsigned START_SPACE_U = 8,
    parameter int unsigned ONE_SPACE_U   = 3,
    parameter int unsigned GAP_U         = 8
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    ir_tx_encoder_if.slave    bus,
    output logic              IR_OUT,
    output logic              IR_ENV,
    output logic              BUSY,
    output logic              TX_DONE
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned S_MARK_CYC  = START_MARK_U * UNIT_CYCLES;
    localparam int unsigned S_SPACE_CYC = START_SPACE_U * UNIT_CYCLES;
    localparam int unsigned ONE_CYC     = ONE_SPACE_U * UNIT_CYCLES;
    localparam int unsigned GAP_CYC     = GAP_U * UNIT_CYCLES;
    localparam int unsigned MAX_CYC     = max2(max2(S_MARK_CYC, S_SPACE_CYC),
                                               max2(max2(ONE_CYC, GAP_CYC), UNIT_CYCLES));
    localparam int TW   = $clog2(MAX_CYC + 1);
    localparam int CW   = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, S_MARK, S_SPACE, B_MARK, B_SPACE, STOP, GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [7:0]        shift_reg, shift_next;
    logic [2:0]        bit_reg, bit_next;
    logic [CNTW-1:0]   count_reg, count_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     carrier_reg;
    logic              env_reg, out_reg, done_reg, busy_reg, full_reg;
    logic [7:0]        mem [FIFO_DEPTH];

    logic push, pop, frame_slot, mark_next, mark_entry, done_next, busy_next, full_next;

    function automatic logic is_mark(input state_t s);
        return (s == S_MARK) || (s == B_MARK) || (s == STOP);
    endfunction

    assign push = bus.ENQUEUE & ~full_reg;

    // The last GAP cycle makes the same pop decision as IDLE, so queued frames
    // are separated by exactly the gap and never start before it completes.
    assign frame_slot = (state_reg == IDLE) || ((state_reg == GAP) && (timer_reg == '0));

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
        pop        = 1'b0;

        if ((state_reg != IDLE) && (timer_reg != '0)) begin
            timer_next = timer_reg - TW'(1);
        end else begin
            case (state_reg)
                S_MARK: begin
                    state_next = S_SPACE;
                    timer_next = TW'(S_SPACE_CYC - 1);
                end
                S_SPACE: begin
                    state_next = B_MARK;
                    timer_next = TW'(UNIT_CYCLES - 1);
                end
                B_MARK: begin
                    state_next = B_SPACE;
                    timer_next = shift_reg[0] ? TW'(ONE_CYC - 1) : TW'(UNIT_CYCLES - 1);
                end
                B_SPACE: begin
                    timer_next = TW'(UNIT_CYCLES - 1);
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        state_next = B_MARK;
                        shift_next = shift_reg >> 1;
                        bit_next   = bit_reg + 3'd1;
                    end
                end
                STOP: begin
                    state_next = GAP;
                    timer_next = TW'(GAP_CYC - 1);
                end
                GAP:     state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end

        if (frame_slot && (count_reg != '0)) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            bit_next   = 3'd0;
            state_next = S_MARK;
            timer_next = TW'(S_MARK_CYC - 1);
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    assign mark_next  = is_mark(state_next);
    assign mark_entry = mark_next && !is_mark(state_reg);
    assign done_next  = (state_next == STOP) && (timer_next == '0);
    assign busy_next  = (state_next != IDLE) || (count_next != '0);
    assign full_next  = (count_next == CNTW'(FIFO_DEPTH));

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            shift_reg   <= '0;
            bit_reg     <= '0;
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            carrier_reg <= '0;
            env_reg     <= 1'b0;
            out_reg     <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            full_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            env_reg  <= mark_next;
            done_reg <= done_next;
            busy_reg <= busy_next;
            full_reg <= full_next;

            // Carrier phase restarts on every mark entry so each mark begins high.
            if (!mark_next) begin
                out_reg     <= 1'b0;
                carrier_reg <= '0;
            end else if (mark_entry) begin
                out_reg     <= 1'b1;
                carrier_reg <= '0;
            end else if (carrier_reg == CW'(CARRIER_HALF - 1)) begin
                out_reg     <= ~out_reg;
                carrier_reg <= '0;
            end else begin
                carrier_reg <= carrier_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr_reg] <= bus.MSG;
    end

    assign bus.BUF_FULL = full_reg;
    assign IR_OUT       = out_reg;
    assign IR_ENV       = env_reg;
    assign BUSY         = busy_reg;
    assign TX_DONE      = done_reg;

endmodule

// File: tb/tb_ir_tx_encoder.sv
// Bench for ir_tx_encoder: a frame-waveform reference model checks every cycle,
// plus a vector table and hand-written sequences for FIFO, gap and reset cases.
module tb_ir_tx_encoder;
    localparam int U     = 4;
    localparam int CH    = 1;
    localparam int DEPTH = 4;

    logic PCLK = 1'b0;
    logic PRESERN;
    logic IR_OUT, IR_ENV, BUSY, TX_DONE;

    ir_tx_encoder_if bus();

    ir_tx_encoder #(.FIFO_DEPTH(DEPTH), .UNIT_CYCLES(U), .CARRIER_HALF(CH)) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .bus     (bus),
        .IR_OUT  (IR_OUT),
        .IR_ENV  (IR_ENV),
        .BUSY    (BUSY),
        .TX_DONE (TX_DONE)
    );

    initial forever #5 PCLK = ~PCLK;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference model: each accepted byte becomes a list of per-cycle
    // {env, carrier, done} entries built directly from the frame timing rules.
    typedef logic [2:0] ent_t;
    logic [7:0] mq[$];
    ent_t       wq[$];
    logic       exp_full = 0, exp_busy = 0, exp_env = 0, exp_out = 0, exp_done = 0;
    int         rem = 0;
    int         pre_sz;
    logic       took;
    ent_t       cur;

    function automatic void add_run(input logic mark, input int n, input logic done_last);
        for (int i = 0; i < n; i++)
            wq.push_back({mark, mark && (((i / CH) % 2) == 0), done_last && (i == n - 1)});
    endfunction

    function automatic void build_frame(input logic [7:0] b);
        add_run(1'b1, 16 * U, 1'b0);
        add_run(1'b0, 8 * U, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add_run(1'b1, U, 1'b0);
            add_run(1'b0, b[i] ? 3 * U : U, 1'b0);
        end
        add_run(1'b1, U, 1'b1);
        add_run(1'b0, 8 * U, 1'b0);
    endfunction

    always @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            mq.delete();
            wq.delete();
            {exp_full, exp_busy, exp_env, exp_out, exp_done} = '0;
            rem = 0;
        end else begin
            pre_sz = mq.size();
            if (wq.size() == 0 && pre_sz > 0) build_frame(mq.pop_front());
            if (bus.ENQUEUE && pre_sz < DEPTH) mq.push_back(bus.MSG);
            took = (wq.size() > 0);
            cur  = took ? wq.pop_front() : 3'b000;
            {exp_env, exp_out, exp_done} = cur;
            exp_busy = took || (mq.size() > 0);
            exp_full = (mq.size() == DEPTH);
            rem      = wq.size();
        end
    end

    always @(negedge PCLK) begin
        checks++;
        if ({bus.BUF_FULL, BUSY, IR_ENV, IR_OUT, TX_DONE} !==
            {exp_full, exp_busy, exp_env, exp_out, exp_done}) begin
            errors++;
            if (errors <= 30)
                $display("FAIL cycle_model t=%0t full/busy/env/out/done got=%b want=%b", $time,
                         {bus.BUF_FULL, BUSY, IR_ENV, IR_OUT, TX_DONE},
                         {exp_full, exp_busy, exp_env, exp_out, exp_done});
        end
        if (TX_DONE) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge PCLK);
        bus.ENQUEUE = 1'b1;
        bus.MSG     = b;
        @(negedge PCLK);
        bus.ENQUEUE = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while (BUSY && n < maxc) begin
            @(negedge PCLK);
            n++;
        end
        if (BUSY) begin
            checks++;
            errors++;
            $display("FAIL %s: BUSY still 1 after %0d cycles, want 0", name, n);
        end
        repeat (2) @(negedge PCLK);
    endtask

    typedef struct {
        logic [7:0] msg;
        int         done_t;
        int         env_hi;
        int         idle_t;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int t, env_cnt, done_t, idle_t, n, snap, bad;

        // Cycle 1 = first cycle after the pop edge; idle_t = first cycle with BUSY=0.
        vecs[0] = '{8'hA5, 196, 100, 229};
        vecs[1] = '{8'h00, 164, 100, 197};
        vecs[2] = '{8'hFF, 228, 100, 261};
        vecs[3] = '{8'h01, 172, 100, 205};
        vecs[4] = '{8'h80, 172, 100, 205};

        PRESERN     = 1'b1;
        bus.ENQUEUE = 1'b0;
        bus.MSG     = 8'h00;
        #1 PRESERN  = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset_outputs", int'({bus.BUF_FULL, BUSY, IR_ENV, IR_OUT, TX_DONE}), 0);
        PRESERN = 1'b1;
        repeat (2) @(negedge PCLK);

        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].msg);
            check("enq_busy", int'(BUSY), 1);
            t = 0; env_cnt = 0; done_t = -1; idle_t = -1;
            while (idle_t < 0 && t < 400) begin
                @(negedge PCLK);
                t++;
                if (IR_ENV) env_cnt++;
                if (TX_DONE && done_t < 0) done_t = t;
                if (!BUSY) idle_t = t;
            end
            check($sformatf("vec%0d_done_cycle", v), done_t, vecs[v].done_t);
            check($sformatf("vec%0d_env_high", v), env_cnt, vecs[v].env_hi);
            check($sformatf("vec%0d_idle_cycle", v), idle_t, vecs[v].idle_t);
        end

        // Back-to-back 0x00 then 0xFF: exact gap and second frame length.
        @(negedge PCLK);
        bus.ENQUEUE = 1'b1; bus.MSG = 8'h00;
        @(negedge PCLK);
        bus.MSG = 8'hFF;
        @(negedge PCLK);
        bus.ENQUEUE = 1'b0;
        n = 0;
        while (!TX_DONE && n < 400) begin @(negedge PCLK); n++; end
        check("first_done_seen", int'(TX_DONE), 1);
        n = 0;
        @(negedge PCLK);
        while (!IR_ENV && n < 100) begin n++; @(negedge PCLK); end
        check("gap_low_cycles", n, 8 * U);
        t = 1;
        while (!TX_DONE && t < 400) begin @(negedge PCLK); t++; end
        check("ff_frame_done_cycle", t, 228);
        wait_idle(600, "gap_seq_idle");

        // Fill the FIFO behind a running frame, overflow, then enqueue on the pop edge.
        snap = done_cnt;
        send_byte(8'h11);
        repeat (2) @(negedge PCLK);
        bus.ENQUEUE = 1'b1; bus.MSG = 8'h22;
        @(negedge PCLK); bus.MSG = 8'h33;
        @(negedge PCLK); bus.MSG = 8'h44;
        @(negedge PCLK);
        check("not_full_after_3", int'(bus.BUF_FULL), 0);
        bus.MSG = 8'h55;
        @(negedge PCLK);
        check("full_after_4", int'(bus.BUF_FULL), 1);
        bus.MSG = 8'h66;
        @(negedge PCLK);
        bus.ENQUEUE = 1'b0;
        check("full_after_drop", int'(bus.BUF_FULL), 1);
        n = 0;
        while (rem != 0 && n < 600) begin @(negedge PCLK); n++; end
        bus.ENQUEUE = 1'b1; bus.MSG = 8'h77;
        @(negedge PCLK);
        check("pop_edge_push_dropped", int'(bus.BUF_FULL), 0);
        bus.MSG = 8'h88;
        @(negedge PCLK);
        bus.ENQUEUE = 1'b0;
        check("retry_accepted", int'(bus.BUF_FULL), 1);
        wait_idle(2000, "fill_seq_idle");
        check("fill_seq_frames", done_cnt - snap, 6);

        // Reset in the middle of bit 0's space with two bytes still queued.
        @(negedge PCLK);
        bus.ENQUEUE = 1'b1; bus.MSG = 8'hA5;
        @(negedge PCLK); bus.MSG = 8'h3C;
        @(negedge PCLK); bus.MSG = 8'hC3;
        @(negedge PCLK); bus.ENQUEUE = 1'b0;
        repeat (103) @(negedge PCLK);
        check("pre_reset_in_space", int'({BUSY, IR_ENV}), 2);
        snap = done_cnt;
        #2 PRESERN = 1'b0;
        #1 check("async_reset_outputs", int'({bus.BUF_FULL, BUSY, IR_ENV, IR_OUT, TX_DONE}), 0);
        repeat (3) @(negedge PCLK);
        PRESERN = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge PCLK);
            if (IR_ENV || BUSY) bad++;
        end
        check("post_reset_quiet", bad, 0);
        check("post_reset_no_done", done_cnt - snap, 0);

        // ENQUEUE held low while MSG wanders.
        bad = 0;
        repeat (1000) begin
            @(negedge PCLK);
            bus.MSG = 8'($urandom);
            if (IR_OUT || IR_ENV || BUSY || bus.BUF_FULL) bad++;
        end
        check("idle_msg_toggle", bad, 0);

        // Random traffic against the model.
        repeat (4000) begin
            @(negedge PCLK);
            bus.ENQUEUE = ($urandom_range(0, 59) == 0);
            bus.MSG     = 8'($urandom);
        end
        bus.ENQUEUE = 1'b0;
        wait_idle(3000, "random_idle");
        check("random_model_drained", mq.size() + wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
